// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer: polyphonic PCM mixer feeding a codec DAC write port; define AUDIO_MIX_LOOP_EN to add per-voice looping
module audio_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 16,
    parameter int ADDR_W     = 14
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [NUM_VOICES-1:0]        trigger,
    input  logic [NUM_VOICES*ADDR_W-1:0] start_addr,
    input  logic [NUM_VOICES*ADDR_W-1:0] clip_len,
`ifdef AUDIO_MIX_LOOP_EN
    input  logic [NUM_VOICES-1:0]        loop_en,
`endif
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [SAMPLE_W-1:0]          mem_rdata,
    input  logic                         audio_out_allowed,
    output logic                         write_audio_out,
    output logic [31:0]                  left_channel_audio_out,
    output logic [31:0]                  right_channel_audio_out,
    output logic [NUM_VOICES-1:0]        voice_busy
);
    localparam int ACC_W = SAMPLE_W + 3;
    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    typedef enum logic [1:0] {IDLE, FETCH, ACC, OUT} state_t;
    state_t                  state_q, state_d;
    logic [VW-1:0]           v_q, v_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic                    write_q, write_d;
    logic [31:0]             out_q, out_d;
    logic [NUM_VOICES-1:0]   active_q, active_d;
    logic [ADDR_W-1:0]       ptr_q [NUM_VOICES];
    logic [ADDR_W-1:0]       ptr_d [NUM_VOICES];
    logic [ADDR_W-1:0]       rem_q [NUM_VOICES];
    logic [ADDR_W-1:0]       rem_d [NUM_VOICES];
    logic signed [ACC_W-1:0] sample_ext;
    logic [SAMPLE_W-1:0]     sat;
    logic                    last_voice;
    assign sample_ext = {{3{mem_rdata[SAMPLE_W-1]}}, mem_rdata};
    assign sat = acc_q > SAT_MAX ? SAT_MAX[SAMPLE_W-1:0] :
                 acc_q < SAT_MIN ? SAT_MIN[SAMPLE_W-1:0] : acc_q[SAMPLE_W-1:0];
    assign last_voice = v_q == VW'(NUM_VOICES - 1);
    // Frame sequencer; IDLE waits out the strobe cycle so the FIFO's room flag reflects the write just made
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        acc_d      = acc_q;
        mem_addr_d = mem_addr_q;
        write_d    = 1'b0;
        out_d      = out_q;
        case (state_q)
            IDLE: begin
                if (audio_out_allowed && !write_q) begin
                    acc_d   = '0;
                    v_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_addr_d = ptr_q[v_q];
                state_d    = ACC;
            end
            ACC: begin
                acc_d   = active_q[v_q] ? acc_q + sample_ext : acc_q;
                v_d     = last_voice ? v_q : v_q + VW'(1);
                state_d = last_voice ? OUT : FETCH;
            end
            OUT: begin
                out_d   = {sat, {(32 - SAMPLE_W){1'b0}}};
                write_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Per-voice playback state; a trigger overrides the advance made while that voice accumulates
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            ptr_d[i]    = ptr_q[i];
            rem_d[i]    = rem_q[i];
            active_d[i] = active_q[i];
            if (state_q == ACC && v_q == VW'(i) && active_q[i]) begin
                ptr_d[i]    = ptr_q[i] + ADDR_W'(1);
                rem_d[i]    = rem_q[i] - ADDR_W'(1);
                active_d[i] = rem_q[i] != ADDR_W'(1);
`ifdef AUDIO_MIX_LOOP_EN
                if (loop_en[i] && rem_q[i] == ADDR_W'(1)) begin
                    ptr_d[i]    = start_addr[i*ADDR_W +: ADDR_W];
                    rem_d[i]    = clip_len[i*ADDR_W +: ADDR_W];
                    active_d[i] = clip_len[i*ADDR_W +: ADDR_W] != '0;
                end
`endif
            end
            if (trigger[i]) begin
                ptr_d[i]    = start_addr[i*ADDR_W +: ADDR_W];
                rem_d[i]    = clip_len[i*ADDR_W +: ADDR_W];
                active_d[i] = clip_len[i*ADDR_W +: ADDR_W] != '0;
            end
        end
    end
    // State registers; reset aborts any frame in flight without a strobe
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            v_q        <= '0;
            acc_q      <= '0;
            mem_addr_q <= '0;
            write_q    <= 1'b0;
            out_q      <= '0;
            active_q   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                ptr_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            acc_q      <= acc_d;
            mem_addr_q <= mem_addr_d;
            write_q    <= write_d;
            out_q      <= out_d;
            active_q   <= active_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                ptr_q[i] <= ptr_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end
    assign mem_addr                = mem_addr_q;
    assign write_audio_out         = write_q;
    assign left_channel_audio_out  = out_q;
    assign right_channel_audio_out = out_q;
    assign voice_busy              = active_q;
endmodule

// File: tb/tb_audio_voice_mixer.sv
// tb_audio_voice_mixer: directed and randomized frames checked against a per-voice clip playback model
module tb_audio_voice_mixer;
    localparam int NV = 4;
    localparam int SW = 16;
    localparam int AW = 14;
    logic             clk = 1'b0;
    logic             rst;
    logic [NV-1:0]    trigger;
    logic [NV*AW-1:0] start_addr, clip_len;
    logic [AW-1:0]    mem_addr;
    logic [SW-1:0]    mem_rdata;
    logic             allowed, write;
    logic [31:0]      left, right;
    logic [NV-1:0]    voice_busy;
`ifdef AUDIO_MIX_LOOP_EN
    logic [NV-1:0]    loop_en;
`endif
    logic [SW-1:0]    mem [1 << AW];
    int               checks = 0;
    int               errors = 0;
    int               m_ptr [NV];
    int               m_rem [NV];
    bit               m_act [NV];
    assign mem_rdata = mem[mem_addr];
    always #10 clk = ~clk;
    audio_voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ADDR_W(AW)) dut (
        .CLOCK_50(clk), .reset(rst), .trigger(trigger), .start_addr(start_addr), .clip_len(clip_len),
`ifdef AUDIO_MIX_LOOP_EN
        .loop_en(loop_en),
`endif
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .audio_out_allowed(allowed),
        .write_audio_out(write), .left_channel_audio_out(left), .right_channel_audio_out(right),
        .voice_busy(voice_busy)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic bit loops(input int v);
`ifdef AUDIO_MIX_LOOP_EN
        return loop_en[v];
`else
        return v < 0;
`endif
    endfunction
    function automatic logic [NV-1:0] m_busy();
        logic [NV-1:0] b;
        for (int v = 0; v < NV; v++) b[v] = m_act[v];
        return b;
    endfunction
    task automatic model_load(input int v);
        m_ptr[v] = int'(start_addr[v*AW +: AW]);
        m_rem[v] = int'(clip_len[v*AW +: AW]);
        m_act[v] = m_rem[v] != 0;
    endtask
    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_ptr[v] = 0;
            m_rem[v] = 0;
            m_act[v] = 0;
        end
    endtask
    // One output frame: every playing voice contributes its next sample, then the sum is clipped
    task automatic model_frame(output logic [31:0] e);
        int s = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_act[v]) begin
                s += int'($signed(mem[m_ptr[v]]));
                m_ptr[v] = (m_ptr[v] + 1) % (1 << AW);
                m_rem[v]--;
                if (m_rem[v] == 0) begin
                    if (loops(v)) model_load(v);
                    else m_act[v] = 0;
                end
            end
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        e = 32'(s) << 16;
    endtask
    task automatic set_voice(input int v, input int a, input int l);
        start_addr[v*AW +: AW] = AW'(a);
        clip_len[v*AW +: AW]   = AW'(l);
    endtask
    task automatic trig(input logic [NV-1:0] m);
        @(negedge clk);
        trigger = m;
        for (int v = 0; v < NV; v++) if (m[v]) model_load(v);
        @(negedge clk);
        trigger = '0;
        check("busy_after_trig", voice_busy, m_busy());
    endtask
    task automatic frame(input bit hold, input int want_n, input int trig_at, input logic [NV-1:0] tmask,
                         input string tag);
        logic [31:0] e;
        int n = 0;
        allowed = 1'b1;
        do begin
            @(negedge clk);
            n++;
            trigger = (n == trig_at) ? tmask : '0;
        end while (!write && n < 40);
        trigger = '0;
        model_frame(e);
        if (trig_at > 0) for (int v = 0; v < NV; v++) if (tmask[v]) model_load(v);
        check({tag, "_latency"}, n, want_n);
        check({tag, "_left"}, left, e);
        check({tag, "_right"}, right, e);
        check({tag, "_busy"}, voice_busy, m_busy());
        if (!hold) begin
            allowed = 1'b0;
            @(negedge clk);
        end
    endtask
    initial begin
        int seen;
        logic [AW-1:0] addr0;
        logic [NV-1:0] m;
        int a;
        rst = 1'b1;
        trigger = '0;
        allowed = 1'b0;
        start_addr = '0;
        clip_len = '0;
`ifdef AUDIO_MIX_LOOP_EN
        loop_en = '0;
`endif
        for (int i = 0; i < (1 << AW); i++) mem[i] = SW'($urandom);
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_write", write, 0);
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_busy", voice_busy, 0);
        rst = 1'b0;
        @(negedge clk);
        mem['h100] = 16'h1000;
        mem['h101] = 16'h2000;
        mem['h102] = 16'hF000;
        set_voice(0, 'h100, 3);
        trig(4'b0001);
        frame(1, 10, 0, '0, "sv1");
        check("sv1_const", left, 32'h1000_0000);
        frame(1, 11, 0, '0, "sv2");
        check("sv2_const", left, 32'h2000_0000);
        frame(1, 11, 0, '0, "sv3");
        check("sv3_const", left, 32'hF000_0000);
        frame(0, 11, 0, '0, "sv4");
        check("sv4_const", left, 32'h0);
        for (int v = 0; v < NV; v++) begin
            set_voice(v, 'h200 + v, 1);
            mem['h200 + v] = 16'h7FFF;
        end
        trig(4'b1111);
        frame(0, 10, 0, '0, "satp");
        check("satp_const", left, 32'h7FFF_0000);
        for (int v = 0; v < NV; v++) mem['h200 + v] = 16'h8000;
        trig(4'b1111);
        frame(0, 10, 0, '0, "satn");
        check("satn_const", left, 32'h8000_0000);
        mem['h300] = 16'h1234;
        mem['h301] = 16'hFF00;
        set_voice(2, 'h300, 2);
        trig(4'b0100);
        addr0 = mem_addr;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (write) seen++;
        end
        check("hold_nostrobe", seen, 0);
        check("hold_addr", mem_addr, addr0);
        frame(0, 10, 0, '0, "hold_rel");
        check("hold_const", left, 32'h1234_0000);
        for (int i = 0; i < 4; i++) mem['h400 + i] = SW'((i + 1) * 'h100);
        set_voice(1, 'h400, 4);
        trig(4'b0010);
        frame(0, 10, 0, '0, "rt0");
        frame(0, 10, 4, 4'b0010, "rt1");
        check("rt1_const", left, 32'h0200_0000);
        frame(0, 10, 0, '0, "rt2");
        check("rt2_const", left, 32'h0100_0000);
        frame(0, 10, 0, '0, "rt3");
        frame(0, 10, 0, '0, "rt4");
        frame(0, 10, 0, '0, "rt5");
        check("rt5_idle", voice_busy[1], 0);
        for (int v = 0; v < NV; v++) set_voice(v, 'h500 + 8 * v, 5);
        trig(4'b1111);
        frame(0, 10, 0, '0, "pre_rst");
        allowed = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        allowed = 1'b0;
        #1;
        check("mid_rst_left", left, 0);
        check("mid_rst_right", right, 0);
        check("mid_rst_write", write, 0);
        check("mid_rst_busy", voice_busy, 0);
        check("mid_rst_addr", mem_addr, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (write) seen++;
        end
        check("post_rst_nostrobe", seen, 0);
`ifdef AUDIO_MIX_LOOP_EN
        mem['h600] = 16'h0111;
        mem['h601] = 16'h0222;
        loop_en = 4'b0001;
        set_voice(0, 'h600, 2);
        trig(4'b0001);
        for (int k = 0; k < 4; k++) begin
            frame(0, 10, 0, '0, "loop");
            check("loop_const", left, (k % 2 == 0) ? 32'h0111_0000 : 32'h0222_0000);
            check("loop_busy0", voice_busy[0], 1);
        end
        loop_en = '0;
        set_voice(0, 0, 0);
        trig(4'b0001);
`endif
        for (int it = 0; it < 24; it++) begin
            m = NV'($urandom);
            for (int v = 0; v < NV; v++) begin
                if (m[v]) begin
                    a = ($urandom_range(0, 3) == 0) ? $urandom_range((1 << AW) - 6, (1 << AW) - 1)
                                                    : $urandom_range(0, (1 << AW) - 1);
                    set_voice(v, a, $urandom_range(0, 6));
                end
            end
            if (m != '0) trig(m);
            frame(0, 10, 0, '0, "rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
